// File: rtl/assoc_pkg.sv
// rtl/assoc_pkg.sv - shared encodings, FSM state type and default widths for the associative command issuer
//
// Contents:
//   KEY_WIDTH_DEF / DATA_WIDTH_DEF / CTRL_WIDTH_DEF : default buffer interface widths
//   CTRL_NONE / CTRL_CLR / CTRL_LOAD / CTRL_INCR    : buffer ctrl codes
//   issuer_state_e                                  : issuer FSM states

package assoc_pkg;

    localparam int KEY_WIDTH_DEF  = 5;
    localparam int DATA_WIDTH_DEF = 8;
    localparam int CTRL_WIDTH_DEF = 2;

    localparam int CTRL_NONE = 0;
    localparam int CTRL_CLR  = 1;
    localparam int CTRL_LOAD = 2;
    localparam int CTRL_INCR = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } issuer_state_e;

endpackage

// File: rtl/assoc_cmd_fifo.sv
// rtl/assoc_cmd_fifo.sv - parameterised synchronous command FIFO
//
// Ports:
//   clk    in   clock, rising edge
//   rst    in   asynchronous active-low reset, empties the FIFO
//   push   in   write request; ignored while full (even if popping the same cycle)
//   wdata  in   WIDTH  entry to write
//   pop    in   read request; ignored while empty
//   rdata  out  WIDTH  head entry (valid while !empty)
//   full   out  DEPTH entries held
//   empty  out  no entries held
//   count  out  $clog2(DEPTH)+1  entries held

module assoc_cmd_fifo #(
    parameter int WIDTH = 15,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic [AW:0]      count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        count_d = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage carries no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/assoc_cmd_issuer.sv
// rtl/assoc_cmd_issuer.sv - queues host commands and issues them one at a time to the associative buffer
//
// Optional feature macro: ASSOC_CMD_ISSUER_STATS_EN (hit/miss counters with synchronous clear)
//
// Ports:
//   clk         in   clock, rising edge
//   rst         in   asynchronous active-low reset; drops in-flight and queued commands
//   cmd_valid   in   host command present
//   cmd_ready   out  command FIFO not full
//   cmd_ctrl    in   CTRL_WIDTH  0=NONE 1=CLR 2=LOAD 3=INCR
//   cmd_key     in   KEY_WIDTH   command key
//   cmd_data    in   DATA_WIDTH  command data
//   buf_ctrl    out  CTRL_WIDTH  registered, non-NONE for exactly one cycle per command
//   buf_key     out  KEY_WIDTH   registered, held after issue
//   buf_data    out  DATA_WIDTH  registered, held after issue
//   buf_result  in   DATA_WIDTH  buffer data_output
//   buf_hit     in   buffer valid
//   rsp_valid   out  response available
//   rsp_ready   in   host accepts the response
//   rsp_data    out  DATA_WIDTH  captured buf_result
//   rsp_hit     out  captured buf_hit
//   stats_clr   in   (stats only) synchronous clear of both counters
//   hit_count   out  (stats only) 16-bit saturating hit counter
//   miss_count  out  (stats only) 16-bit saturating miss counter

module assoc_cmd_issuer
    import assoc_pkg::*;
#(
    parameter int KEY_WIDTH  = KEY_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int CTRL_WIDTH = CTRL_WIDTH_DEF,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [CTRL_WIDTH-1:0] cmd_ctrl,
    input  logic [KEY_WIDTH-1:0]  cmd_key,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    output logic [CTRL_WIDTH-1:0] buf_ctrl,
    output logic [KEY_WIDTH-1:0]  buf_key,
    output logic [DATA_WIDTH-1:0] buf_data,
    input  logic [DATA_WIDTH-1:0] buf_result,
    input  logic                  buf_hit,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_hit
`ifdef ASSOC_CMD_ISSUER_STATS_EN
    ,
    input  logic                  stats_clr,
    output logic [15:0]           hit_count,
    output logic [15:0]           miss_count
`endif
);

    localparam int ENTRY_W = CTRL_WIDTH + KEY_WIDTH + DATA_WIDTH;
    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;

    issuer_state_e         state_q;
    logic [CTRL_WIDTH-1:0] buf_ctrl_q;
    logic [KEY_WIDTH-1:0]  buf_key_q;
    logic [DATA_WIDTH-1:0] buf_data_q;
    logic                  rsp_valid_q;
    logic [DATA_WIDTH-1:0] rsp_data_q;
    logic                  rsp_hit_q;

    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [ENTRY_W-1:0]    fifo_wdata;
    logic [ENTRY_W-1:0]    fifo_rdata;
    // Queue level is exposed by the FIFO for observability; the issuer only needs full/empty.
    logic [CNT_W-1:0]      unused_fifo_count;

    logic [CTRL_WIDTH-1:0] head_ctrl;
    logic [KEY_WIDTH-1:0]  head_key;
    logic [DATA_WIDTH-1:0] head_data;

    assign cmd_ready  = !fifo_full;
    assign fifo_push  = cmd_valid && cmd_ready;
    assign fifo_wdata = {cmd_ctrl, cmd_key, cmd_data};
    // Only IDLE consumes from the queue, which is what keeps one command in flight.
    assign fifo_pop   = (state_q == ST_IDLE) && !fifo_empty;
    assign {head_ctrl, head_key, head_data} = fifo_rdata;

    assoc_cmd_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .wdata (fifo_wdata),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (unused_fifo_count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            buf_ctrl_q  <= CTRL_WIDTH'(CTRL_NONE);
            buf_key_q   <= '0;
            buf_data_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_hit_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        buf_ctrl_q <= head_ctrl;
                        buf_key_q  <= head_key;
                        buf_data_q <= head_data;
                        state_q    <= ST_ISSUE;
                    end else begin
                        buf_ctrl_q <= CTRL_WIDTH'(CTRL_NONE);
                    end
                end
                ST_ISSUE: begin
                    // Key/data stay put so the buffer keeps addressing the same entry.
                    buf_ctrl_q <= CTRL_WIDTH'(CTRL_NONE);
                    state_q    <= ST_WAIT;
                end
                ST_WAIT: begin
                    rsp_data_q  <= buf_result;
                    rsp_hit_q   <= buf_hit;
                    rsp_valid_q <= 1'b1;
                    state_q     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign buf_ctrl  = buf_ctrl_q;
    assign buf_key   = buf_key_q;
    assign buf_data  = buf_data_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_hit   = rsp_hit_q;

`ifdef ASSOC_CMD_ISSUER_STATS_EN
    logic [15:0] hit_count_q;
    logic [15:0] miss_count_q;
    logic        capture;

    assign capture = (state_q == ST_WAIT);

    // Clear wins over a same-cycle capture; counters stick at all-ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else if (stats_clr) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else if (capture) begin
            if (buf_hit) begin
                if (hit_count_q != 16'hFFFF) begin
                    hit_count_q <= hit_count_q + 16'd1;
                end
            end else begin
                if (miss_count_q != 16'hFFFF) begin
                    miss_count_q <= miss_count_q + 16'd1;
                end
            end
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_assoc_cmd_issuer.sv
// tb/tb_assoc_cmd_issuer.sv - directed self-checking bench for assoc_cmd_issuer

module tb_assoc_cmd_issuer;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_ctrl;
    logic [4:0] cmd_key;
    logic [7:0] cmd_data;
    logic [1:0] buf_ctrl;
    logic [4:0] buf_key;
    logic [7:0] buf_data;
    logic [7:0] buf_result;
    logic       buf_hit;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_hit;
`ifdef ASSOC_CMD_ISSUER_STATS_EN
    logic        stats_clr;
    logic [15:0] hit_count;
    logic [15:0] miss_count;
`endif

    int total = 0;
    int bad   = 0;

    assoc_cmd_issuer #(
        .KEY_WIDTH  (5),
        .DATA_WIDTH (8),
        .CTRL_WIDTH (2),
        .FIFO_DEPTH (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_ctrl   (cmd_ctrl),
        .cmd_key    (cmd_key),
        .cmd_data   (cmd_data),
        .buf_ctrl   (buf_ctrl),
        .buf_key    (buf_key),
        .buf_data   (buf_data),
        .buf_result (buf_result),
        .buf_hit    (buf_hit),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_hit    (rsp_hit)
`ifdef ASSOC_CMD_ISSUER_STATS_EN
        ,
        .stats_clr  (stats_clr),
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered associative buffer stand-in: one-cycle result latency.
    logic [7:0]  bm_mem [32];
    logic [31:0] bm_vld;

    always @(posedge clk) begin
        if (!rst) begin
            bm_vld     <= '0;
            buf_result <= 8'h00;
            buf_hit    <= 1'b0;
        end else begin
            case (buf_ctrl)
                2'd1: begin
                    bm_vld[buf_key] <= 1'b0;
                    buf_result      <= 8'h00;
                    buf_hit         <= 1'b0;
                end
                2'd2: begin
                    bm_mem[buf_key] <= buf_data;
                    bm_vld[buf_key] <= 1'b1;
                    buf_result      <= buf_data;
                    buf_hit         <= 1'b1;
                end
                2'd3: begin
                    if (bm_vld[buf_key]) begin
                        bm_mem[buf_key] <= bm_mem[buf_key] + 8'd1;
                        buf_result      <= bm_mem[buf_key] + 8'd1;
                        buf_hit         <= 1'b1;
                    end else begin
                        buf_result <= 8'h00;
                        buf_hit    <= 1'b0;
                    end
                end
                default: begin
                    buf_result <= bm_vld[buf_key] ? bm_mem[buf_key] : 8'h00;
                    buf_hit    <= bm_vld[buf_key];
                end
            endcase
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rsp(output bit ok);
        int n;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 20) begin
            cyc();
            n++;
        end
        ok = (rsp_valid === 1'b1);
    endtask

    task automatic accept();
        rsp_ready = 1'b1;
        cyc();
        rsp_ready = 1'b0;
    endtask

    task automatic push_one(input logic [1:0] c, input logic [4:0] k, input logic [7:0] d);
        cmd_ctrl  = c;
        cmd_key   = k;
        cmd_data  = d;
        cmd_valid = 1'b1;
        cyc();
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b0;
        cmd_valid = 1'b1;
        cmd_ctrl  = 2'd2;
        cmd_key   = 5'h01;
        cmd_data  = 8'h11;
        rsp_ready = 1'b0;
`ifdef ASSOC_CMD_ISSUER_STATS_EN
        stats_clr = 1'b0;
`endif
        repeat (3) cyc();
        cmd_valid = 1'b0;
        rst       = 1'b1;
        #1;
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready got=%b want=1", cmd_ready); end
        total++; if (buf_ctrl !== 2'd0) begin bad++; $display("FAIL reset_buf_ctrl got=%0d want=0", buf_ctrl); end
        total++; if (buf_key !== 5'h00 || buf_data !== 8'h00) begin bad++; $display("FAIL reset_buf_kd got=%h/%h want=00/00", buf_key, buf_data); end
        total++; if (rsp_valid !== 1'b0 || rsp_data !== 8'h00 || rsp_hit !== 1'b0) begin bad++; $display("FAIL reset_rsp got=%b/%h/%b want=0/00/0", rsp_valid, rsp_data, rsp_hit); end
`ifdef ASSOC_CMD_ISSUER_STATS_EN
        total++; if (hit_count !== 16'd0 || miss_count !== 16'd0) begin bad++; $display("FAIL reset_stats got=%0d/%0d want=0/0", hit_count, miss_count); end
`endif
        for (int i = 0; i < 5; i++) begin
            cyc();
            total++; if (buf_ctrl !== 2'd0 || rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_no_push cyc=%0d got=%0d/%b want=0/0", i, buf_ctrl, rsp_valid); end
        end
    endtask

    task automatic test_single_load();
        bit ok;
        cmd_ctrl  = 2'd2;
        cmd_key   = 5'h03;
        cmd_data  = 8'hA5;
        cmd_valid = 1'b1;
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL load_ready got=%b want=1", cmd_ready); end
        cyc();
        cmd_valid = 1'b0;
        total++; if (buf_ctrl !== 2'd0) begin bad++; $display("FAIL load_e0_ctrl got=%0d want=0", buf_ctrl); end
        cyc();
        total++; if (buf_ctrl !== 2'd2 || buf_key !== 5'h03 || buf_data !== 8'hA5) begin bad++; $display("FAIL load_issue got=%0d/%h/%h want=2/03/a5", buf_ctrl, buf_key, buf_data); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL load_e1_valid got=%b want=0", rsp_valid); end
        cyc();
        total++; if (buf_ctrl !== 2'd0 || buf_key !== 5'h03 || buf_data !== 8'hA5) begin bad++; $display("FAIL load_wait got=%0d/%h/%h want=0/03/a5", buf_ctrl, buf_key, buf_data); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL load_e2_valid got=%b want=0", rsp_valid); end
        cyc();
        total++; if (rsp_valid !== 1'b1 || rsp_data !== 8'hA5 || rsp_hit !== 1'b1) begin bad++; $display("FAIL load_rsp got=%b/%h/%b want=1/a5/1", rsp_valid, rsp_data, rsp_hit); end
        cyc();
        total++; if (rsp_valid !== 1'b1 || rsp_data !== 8'hA5) begin bad++; $display("FAIL load_hold got=%b/%h want=1/a5", rsp_valid, rsp_data); end
        accept();
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL load_accept got=%b want=0", rsp_valid); end
        push_one(2'd0, 5'h03, 8'h00);
        wait_rsp(ok);
        total++; if (!ok || rsp_data !== 8'hA5 || rsp_hit !== 1'b1) begin bad++; $display("FAIL lookup_hit got=%b/%h/%b want=1/a5/1", rsp_valid, rsp_data, rsp_hit); end
        accept();
    endtask

    task automatic test_miss();
        bit ok;
        push_one(2'd0, 5'h1F, 8'h99);
        wait_rsp(ok);
        total++; if (!ok || rsp_hit !== 1'b0 || rsp_data !== 8'h00) begin bad++; $display("FAIL miss got=%b/%h/%b want=1/00/0", rsp_valid, rsp_data, rsp_hit); end
        accept();
    endtask

    task automatic test_back_to_back();
        bit ok;
        for (int i = 0; i < 5; i++) begin
            cmd_ctrl  = 2'd2;
            cmd_key   = 5'(4 + i);
            cmd_data  = 8'(8'h10 + i);
            cmd_valid = 1'b1;
            total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL b2b_accept idx=%0d got=%b want=1", i, cmd_ready); end
            cyc();
        end
        cmd_valid = 1'b0;
        total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL b2b_full got=%b want=0", cmd_ready); end
        cmd_ctrl  = 2'd2;
        cmd_key   = 5'h10;
        cmd_data  = 8'hEE;
        cmd_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL b2b_refuse cyc=%0d got=%b want=0", i, cmd_ready); end
            total++; if (rsp_valid !== 1'b1 || rsp_data !== 8'h10) begin bad++; $display("FAIL b2b_stall cyc=%0d got=%b/%h want=1/10", i, rsp_valid, rsp_data); end
        end
        cmd_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wait_rsp(ok);
            total++; if (!ok || rsp_data !== 8'(8'h10 + i) || rsp_hit !== 1'b1) begin bad++; $display("FAIL b2b_order idx=%0d got=%b/%h/%b want=1/%h/1", i, rsp_valid, rsp_data, rsp_hit, 8'(8'h10 + i)); end
            cyc();
            total++; if (rsp_valid !== 1'b1 || rsp_data !== 8'(8'h10 + i)) begin bad++; $display("FAIL b2b_stable idx=%0d got=%b/%h want=1/%h", i, rsp_valid, rsp_data, 8'(8'h10 + i)); end
            accept();
        end
        for (int i = 0; i < 10; i++) begin
            cyc();
            total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL b2b_no_sixth cyc=%0d got=%b want=0", i, rsp_valid); end
        end
    endtask

    task automatic test_reset_mid_wait();
        bit ok;
        cmd_valid = 1'b1;
        cmd_ctrl  = 2'd2; cmd_key = 5'h0A; cmd_data = 8'h5C;
        cyc();
        cmd_ctrl  = 2'd2; cmd_key = 5'h0C; cmd_data = 8'h61;
        cyc();
        cmd_ctrl  = 2'd2; cmd_key = 5'h0D; cmd_data = 8'h62;
        cyc();
        cmd_valid = 1'b0;
        total++; if (buf_ctrl !== 2'd0 || buf_key !== 5'h0A || rsp_valid !== 1'b0) begin bad++; $display("FAIL rstw_in_wait got=%0d/%h/%b want=0/0a/0", buf_ctrl, buf_key, rsp_valid); end
        rst = 1'b0;
        #1;
        total++; if (rsp_valid !== 1'b0 || buf_ctrl !== 2'd0) begin bad++; $display("FAIL rstw_async got=%b/%0d want=0/0", rsp_valid, buf_ctrl); end
        total++; if (buf_key !== 5'h00 || buf_data !== 8'h00) begin bad++; $display("FAIL rstw_async_kd got=%h/%h want=00/00", buf_key, buf_data); end
        repeat (2) cyc();
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            total++; if (rsp_valid !== 1'b0 || buf_ctrl !== 2'd0) begin bad++; $display("FAIL rstw_flushed cyc=%0d got=%b/%0d want=0/0", i, rsp_valid, buf_ctrl); end
        end
        push_one(2'd2, 5'h0B, 8'h77);
        wait_rsp(ok);
        total++; if (!ok || rsp_data !== 8'h77 || rsp_hit !== 1'b1) begin bad++; $display("FAIL rstw_first_after got=%b/%h/%b want=1/77/1", rsp_valid, rsp_data, rsp_hit); end
        accept();
    endtask

`ifdef ASSOC_CMD_ISSUER_STATS_EN
    task automatic test_stats();
        bit ok;
        stats_clr = 1'b1;
        cyc();
        stats_clr = 1'b0;
        push_one(2'd2, 5'h01, 8'h21); wait_rsp(ok); accept();
        push_one(2'd2, 5'h02, 8'h22); wait_rsp(ok); accept();
        push_one(2'd0, 5'h1E, 8'h00); wait_rsp(ok); accept();
        push_one(2'd0, 5'h01, 8'h00); wait_rsp(ok); accept();
        push_one(2'd0, 5'h1D, 8'h00); wait_rsp(ok); accept();
        total++; if (hit_count !== 16'd3 || miss_count !== 16'd2) begin bad++; $display("FAIL stats_count got=%0d/%0d want=3/2", hit_count, miss_count); end
        push_one(2'd2, 5'h03, 8'h33);
        cyc();
        cyc();
        stats_clr = 1'b1;
        cyc();
        stats_clr = 1'b0;
        total++; if (rsp_valid !== 1'b1 || hit_count !== 16'd0 || miss_count !== 16'd0) begin bad++; $display("FAIL stats_clr_prio got=%b/%0d/%0d want=1/0/0", rsp_valid, hit_count, miss_count); end
        accept();
    endtask
`endif

    initial begin
        test_reset();
        test_single_load();
        test_miss();
        test_back_to_back();
        test_reset_mid_wait();
`ifdef ASSOC_CMD_ISSUER_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
